// File: rtl/sobel_window_gen_if.sv
// Pixel stream in, 3x3 Sobel neighbourhood out.
// The slave side is the window generator; the master side is the pixel
// source and window consumer.
interface sobel_window_gen_if #(
    parameter int unsigned XW = 10,
    parameter int unsigned YW = 9
);
    logic          in_valid;
    logic          in_sof;
    logic [7:0]    in_data;
    logic [7:0]    p0;
    logic [7:0]    p1;
    logic [7:0]    p2;
    logic [7:0]    p3;
    logic [7:0]    p5;
    logic [7:0]    p6;
    logic [7:0]    p7;
    logic [7:0]    p8;
    logic          win_valid;
    logic [XW-1:0] win_x;
    logic [YW-1:0] win_y;
    logic          win_last;
    logic          sof_err;

    modport master (
        output in_valid, in_sof, in_data,
        input  p0, p1, p2, p3, p5, p6, p7, p8,
        input  win_valid, win_x, win_y, win_last, sof_err
    );

    modport slave (
        input  in_valid, in_sof, in_data,
        output p0, p1, p2, p3, p5, p6, p7, p8,
        output win_valid, win_x, win_y, win_last, sof_err
    );
endinterface

// File: rtl/sobel_window_gen.sv
// Streaming 3x3 window generator: two line buffers plus a two-column shift
// register; the incoming pixel's column completes the window. One-cycle
// latency from the accept of the bottom-right pixel to win_valid.
module sobel_window_gen #(
    parameter int unsigned IMG_W = 640,
    parameter int unsigned IMG_H = 480,
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9
) (
    input logic              clk,
    input logic              rst,
    sobel_window_gen_if.slave bus_io
);
    logic          accept;
    logic [XW-1:0] col_q, col_d, cur_col;
    logic [YW-1:0] row_q, row_d, cur_row;
    logic          win_fire, last_fire, sof_err_d;

    // Line buffers: lb_a holds line row-1, lb_b holds line row-2.
    logic [7:0] lb_a [IMG_W];
    logic [7:0] lb_b [IMG_W];
    logic [7:0] rd_a, rd_b;

    // c1 = column col-2, c2 = column col-1, as seen by the next accept.
    logic [7:0] c1_top_q, c1_mid_q, c1_bot_q;
    logic [7:0] c2_top_q, c2_mid_q, c2_bot_q;

    logic [7:0]    p0_q, p1_q, p2_q, p3_q, p5_q, p6_q, p7_q, p8_q;
    logic [XW-1:0] win_x_q;
    logic [YW-1:0] win_y_q;
    logic          win_valid_q, win_last_q, sof_err_q;

    assign accept = bus_io.in_valid;

    // Position of the pixel being accepted; in_sof forces it to (0,0).
    always_comb begin
        cur_col = col_q;
        cur_row = row_q;
        if (bus_io.in_sof) begin
            cur_col = '0;
            cur_row = '0;
        end
    end

    // Read-before-write: these are the pre-update contents at cur_col.
    assign rd_a = lb_a[cur_col];
    assign rd_b = lb_b[cur_col];

    // Raster counter advance with wrap at end of line and end of frame.
    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (accept) begin
            if (cur_col == XW'(IMG_W - 1)) begin
                col_d = '0;
                row_d = (cur_row == YW'(IMG_H - 1)) ? '0 : cur_row + YW'(1);
            end else begin
                col_d = cur_col + XW'(1);
                row_d = cur_row;
            end
        end
    end

    // Window / status decode for the current accept.
    always_comb begin
        win_fire  = accept && (cur_row >= YW'(2)) && (cur_col >= XW'(2));
        last_fire = win_fire && (cur_row == YW'(IMG_H - 1)) && (cur_col == XW'(IMG_W - 1));
        sof_err_d = accept && bus_io.in_sof && ((col_q != '0) || (row_q != '0));
    end

    // Counters and column shift register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            col_q    <= '0;
            row_q    <= '0;
            c1_top_q <= '0;
            c1_mid_q <= '0;
            c1_bot_q <= '0;
            c2_top_q <= '0;
            c2_mid_q <= '0;
            c2_bot_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
            if (accept) begin
                c1_top_q <= c2_top_q;
                c1_mid_q <= c2_mid_q;
                c1_bot_q <= c2_bot_q;
                c2_top_q <= rd_b;
                c2_mid_q <= rd_a;
                c2_bot_q <= bus_io.in_data;
            end
        end
    end

    // Line buffer update; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb_b[cur_col] <= rd_a;
            lb_a[cur_col] <= bus_io.in_data;
        end
    end

    // Registered window outputs; data holds between windows.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p0_q        <= '0;
            p1_q        <= '0;
            p2_q        <= '0;
            p3_q        <= '0;
            p5_q        <= '0;
            p6_q        <= '0;
            p7_q        <= '0;
            p8_q        <= '0;
            win_x_q     <= '0;
            win_y_q     <= '0;
            win_valid_q <= 1'b0;
            win_last_q  <= 1'b0;
            sof_err_q   <= 1'b0;
        end else begin
            win_valid_q <= win_fire;
            win_last_q  <= last_fire;
            sof_err_q   <= sof_err_d;
            if (win_fire) begin
                p0_q    <= c1_top_q;
                p1_q    <= c2_top_q;
                p2_q    <= rd_b;
                p3_q    <= c1_mid_q;
                p5_q    <= rd_a;
                p6_q    <= c1_bot_q;
                p7_q    <= c2_bot_q;
                p8_q    <= bus_io.in_data;
                win_x_q <= cur_col - XW'(1);
                win_y_q <= cur_row - YW'(1);
            end
        end
    end

    assign bus_io.p0        = p0_q;
    assign bus_io.p1        = p1_q;
    assign bus_io.p2        = p2_q;
    assign bus_io.p3        = p3_q;
    assign bus_io.p5        = p5_q;
    assign bus_io.p6        = p6_q;
    assign bus_io.p7        = p7_q;
    assign bus_io.p8        = p8_q;
    assign bus_io.win_x     = win_x_q;
    assign bus_io.win_y     = win_y_q;
    assign bus_io.win_valid = win_valid_q;
    assign bus_io.win_last  = win_last_q;
    assign bus_io.sof_err   = sof_err_q;
endmodule
